// File: rtl/ntt_butterfly_pipe.sv
// Pipelined radix-2 NTT/INTT butterfly: CT forward / GS inverse per op, runtime twiddle, Barrett reduction.
// Optional macro BUTTERFLY_INV_HALVE_EN: GS results are additionally multiplied by 2^-1 mod Q.
module ntt_butterfly_pipe #(
  parameter int WIDTH = 28,
  parameter logic [WIDTH-1:0] Q = WIDTH'(268369921),
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] w_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [W2:0] R2 = {1'b1, {W2{1'b0}}};
  localparam logic [W2:0] MU = R2 / {{(W2 + 1 - WIDTH){1'b0}}, Q};
  localparam logic [WIDTH:0] QX = {1'b0, Q};
  localparam logic [WIDTH+1:0] QR = {2'b00, Q};

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QX) s = s - QX;
    return s[WIDTH-1:0];
  endfunction

  // Borrow shows up in the extra top bit; adding Q back wraps to the right residue.
  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[WIDTH]) d = d + QX;
    return d[WIDTH-1:0];
  endfunction

`ifdef BUTTERFLY_INV_HALVE_EN
  function automatic logic [WIDTH-1:0] mod_halve(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] h;
    h = {1'b0, v};
    if (v[0]) h = h + QX;
    return h[WIDTH:1];
  endfunction
`endif

  // Input capture stage
  logic             r_in_v, r_in_mode;
  logic [TAG_W-1:0] r_in_tag;
  logic [WIDTH-1:0] r_in_x, r_in_y, r_in_w;
  // S0 pre-add/sub
  logic             r_s0_v, r_s0_mode;
  logic [TAG_W-1:0] r_s0_tag;
  logic [WIDTH-1:0] r_s0_a, r_s0_b, r_s0_w;
  // S1 product
  logic             r_s1_v, r_s1_mode;
  logic [TAG_W-1:0] r_s1_tag;
  logic [WIDTH-1:0] r_s1_a;
  logic [W2-1:0]    r_s1_p;
  // S2 Barrett estimate
  logic             r_s2_v, r_s2_mode;
  logic [TAG_W-1:0] r_s2_tag;
  logic [WIDTH-1:0] r_s2_a, r_s2_t;
  logic [W2-1:0]    r_s2_p;
  // S3 partial remainder
  logic             r_s3_v, r_s3_mode;
  logic [TAG_W-1:0] r_s3_tag;
  logic [WIDTH-1:0] r_s3_a;
  logic [WIDTH+1:0] r_s3_r;
  // S4 corrected product
  logic             r_s4_v, r_s4_mode;
  logic [TAG_W-1:0] r_s4_tag;
  logic [WIDTH-1:0] r_s4_a, r_s4_m;
  // S5 outputs
  logic             r_out_v;
  logic [TAG_W-1:0] r_out_tag;
  logic [WIDTH-1:0] r_out_x, r_out_y;

  logic [WIDTH-1:0]  w_s0_a, w_s0_b;
  logic [W2-1:0]     w_s1_p;
  logic [2*W2:0]     w_s2_prod;
  logic [WIDTH-1:0]  w_s2_t;
  logic [W2-1:0]     w_s3_tq, w_s3_diff;
  logic [WIDTH+1:0]  w_s4_c;
  logic [WIDTH-1:0]  w_s4_m;
  logic [WIDTH-1:0]  w_s5_x, w_s5_y;
  logic              w_unused_bits;

  assign w_s0_a = r_in_mode ? mod_add(r_in_x, r_in_y) : r_in_x;
  assign w_s0_b = r_in_mode ? mod_sub(r_in_x, r_in_y) : r_in_y;

  assign w_s1_p = {{WIDTH{1'b0}}, r_s0_b} * {{WIDTH{1'b0}}, r_s0_w};

  assign w_s2_prod = {{(W2 + 1){1'b0}}, r_s1_p} * {{W2{1'b0}}, MU};
  assign w_s2_t    = w_s2_prod[W2 +: WIDTH];

  // True remainder is below 3Q, so only the low WIDTH+2 bits of p - t*Q matter.
  assign w_s3_tq   = {{WIDTH{1'b0}}, r_s2_t} * {{WIDTH{1'b0}}, Q};
  assign w_s3_diff = r_s2_p - w_s3_tq;

  always_comb begin
    w_s4_c = r_s3_r;
    if (w_s4_c >= QR) w_s4_c = w_s4_c - QR;
    if (w_s4_c >= QR) w_s4_c = w_s4_c - QR;
    w_s4_m = w_s4_c[WIDTH-1:0];
  end

  always_comb begin
    w_s5_x = mod_add(r_s4_a, r_s4_m);
    w_s5_y = mod_sub(r_s4_a, r_s4_m);
    if (r_s4_mode) begin
`ifdef BUTTERFLY_INV_HALVE_EN
      w_s5_x = mod_halve(r_s4_a);
      w_s5_y = mod_halve(r_s4_m);
`else
      w_s5_x = r_s4_a;
      w_s5_y = r_s4_m;
`endif
    end
  end

  assign w_unused_bits = ^{w_s2_prod[W2-1:0], w_s2_prod[2*W2:W2+WIDTH],
                           w_s3_diff[W2-1:WIDTH+2], w_s4_c[WIDTH+1:WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_v <= 1'b0; r_in_mode <= 1'b0; r_in_tag <= '0;
      r_in_x <= '0; r_in_y <= '0; r_in_w <= '0;
      r_s0_v <= 1'b0; r_s0_mode <= 1'b0; r_s0_tag <= '0;
      r_s0_a <= '0; r_s0_b <= '0; r_s0_w <= '0;
      r_s1_v <= 1'b0; r_s1_mode <= 1'b0; r_s1_tag <= '0;
      r_s1_a <= '0; r_s1_p <= '0;
      r_s2_v <= 1'b0; r_s2_mode <= 1'b0; r_s2_tag <= '0;
      r_s2_a <= '0; r_s2_p <= '0; r_s2_t <= '0;
      r_s3_v <= 1'b0; r_s3_mode <= 1'b0; r_s3_tag <= '0;
      r_s3_a <= '0; r_s3_r <= '0;
      r_s4_v <= 1'b0; r_s4_mode <= 1'b0; r_s4_tag <= '0;
      r_s4_a <= '0; r_s4_m <= '0;
      r_out_v <= 1'b0; r_out_tag <= '0; r_out_x <= '0; r_out_y <= '0;
    end else if (!stall) begin
      r_in_v <= in_valid; r_in_mode <= mode; r_in_tag <= tag_in;
      r_in_x <= x_in; r_in_y <= y_in; r_in_w <= w_in;

      r_s0_v <= r_in_v; r_s0_mode <= r_in_mode; r_s0_tag <= r_in_tag;
      r_s0_a <= w_s0_a; r_s0_b <= w_s0_b; r_s0_w <= r_in_w;

      r_s1_v <= r_s0_v; r_s1_mode <= r_s0_mode; r_s1_tag <= r_s0_tag;
      r_s1_a <= r_s0_a; r_s1_p <= w_s1_p;

      r_s2_v <= r_s1_v; r_s2_mode <= r_s1_mode; r_s2_tag <= r_s1_tag;
      r_s2_a <= r_s1_a; r_s2_p <= r_s1_p; r_s2_t <= w_s2_t;

      r_s3_v <= r_s2_v; r_s3_mode <= r_s2_mode; r_s3_tag <= r_s2_tag;
      r_s3_a <= r_s2_a; r_s3_r <= w_s3_diff[WIDTH+1:0];

      r_s4_v <= r_s3_v; r_s4_mode <= r_s3_mode; r_s4_tag <= r_s3_tag;
      r_s4_a <= r_s3_a; r_s4_m <= w_s4_m;

      r_out_v <= r_s4_v; r_out_tag <= r_s4_tag;
      r_out_x <= w_s5_x; r_out_y <= w_s5_y;
    end
  end

  assign out_valid = r_out_v;
  assign x_out     = r_out_x;
  assign y_out     = r_out_y;
  assign tag_out   = r_out_tag;

endmodule
